// File: rtl/uart_tx_module_pkg.sv
// Shared UART definitions for the TX path.
//   UART_DATA_BITS      : payload bits per frame (8N1)
//   BIT_CLK_PER_DEFAULT : clocks per bit at 100 MHz / 115200 baud
//   tx_state_e          : transmitter FSM states
package uart_tx_module_pkg;

   localparam int unsigned UART_DATA_BITS      = 8;
   localparam int unsigned BIT_CLK_PER_DEFAULT = 868;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
//   clk_i, rst_ni    : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i, rdata_o   : read request; rdata_o always shows the head entry
//   full_o, empty_o  : status derived from the registered count
//   count_o          : entries held; one bit wider than the pointers
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_module.sv
// UART 8N1 transmitter with a small input FIFO.
//   i_clk, i_reset_n       : clock, asynchronous active-low reset
//   i_tx_valid, i_tx_byte  : byte offer; taken when i_tx_valid & o_tx_ready
//   o_tx_ready             : FIFO has room
//   o_tx_serial            : serial line, idle high, LSB first
//   o_tx_active            : high from start-bit edge to the edge ending the stop bit
//   o_tx_done              : one-cycle pulse after each stop bit
//   o_fifo_count           : bytes waiting in the FIFO
module uart_tx_module import uart_tx_module_pkg::*; #(
   parameter int unsigned BIT_CLK_PER = BIT_CLK_PER_DEFAULT,
   parameter int unsigned FIFO_DEPTH  = 4,
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_tx_valid,
   input  logic [UART_DATA_BITS-1:0] i_tx_byte,
   output logic                      o_tx_ready,
   output logic                      o_tx_serial,
   output logic                      o_tx_active,
   output logic                      o_tx_done,
   output logic [CNT_W-1:0]          o_fifo_count
);

   localparam int unsigned BAUD_W = $clog2(BIT_CLK_PER);

   tx_state_e                 state_q, state_d;
   logic [BAUD_W-1:0]         baud_q, baud_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      serial_q, serial_d;
   logic                      active_q, active_d;
   logic                      done_q, done_d;

   logic                      fifo_full, fifo_empty, fifo_pop;
   logic [UART_DATA_BITS-1:0] fifo_rdata;
   logic                      baud_end;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_reset_n),
      .push_i  (i_tx_valid & o_tx_ready),
      .wdata_i (i_tx_byte),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (o_fifo_count)
   );

   assign o_tx_ready  = ~fifo_full;
   assign o_tx_serial = serial_q;
   assign o_tx_active = active_q;
   assign o_tx_done   = done_q;
   assign baud_end    = (baud_q == BAUD_W'(BIT_CLK_PER - 1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         serial_q  <= serial_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      serial_d  = serial_q;
      active_d  = active_q;
      done_d    = 1'b0;
      fifo_pop  = 1'b0;

      case (state_q)
         StIdle: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               serial_d = 1'b0;
               active_d = 1'b1;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d    = '0;
               bit_idx_d = '0;
               serial_d  = shift_q[0];
               state_d   = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                  serial_d = 1'b1;
                  state_d  = StStop;
               end else begin
                  // Next bit is shift_q[1]; it becomes bit 0 after this shift.
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                  serial_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               done_d = 1'b1;
               if (!fifo_empty) begin
                  // Back-to-back frame: start bit begins on this same edge.
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  serial_d = 1'b0;
                  state_d  = StStart;
               end else begin
                  active_d = 1'b0;
                  state_d  = StIdle;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_module.sv
module tb_uart_tx_module;

   localparam int B     = 16;
   localparam int D     = 4;
   localparam int FRAME = 10 * B;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_byte  = 8'h00;
   logic       tx_ready, tx_serial, tx_active, tx_done;
   logic [2:0] fifo_count;

   always #5 clk = ~clk;

   uart_tx_module #(
      .BIT_CLK_PER (B),
      .FIFO_DEPTH  (D)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_tx_valid   (tx_valid),
      .i_tx_byte    (tx_byte),
      .o_tx_ready   (tx_ready),
      .o_tx_serial  (tx_serial),
      .o_tx_active  (tx_active),
      .o_tx_done    (tx_done),
      .o_fifo_count (fifo_count)
   );

   int unsigned chk = 0;
   int unsigned err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         if (err <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: byte queue + frame position ----------------
   logic [7:0] mq[$];
   bit         m_busy = 0;
   int         m_pos  = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_done = 0;

   // Frame bit i: 0 = start, 1..8 = data LSB first, 9 = stop.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      return 1'b1;
   endfunction

   always begin
      bit push_ok, had;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         m_busy = 0;
         m_pos  = 0;
         m_done = 0;
      end else begin
         push_ok = tx_valid && (mq.size() < D);
         had     = (mq.size() > 0);
         m_done  = 0;
         if (m_busy) begin
            if (m_pos == FRAME - 1) begin
               m_done = 1;
               m_busy = 0;
            end else begin
               m_pos++;
            end
         end
         if (!m_busy && had) begin
            m_byte = mq.pop_front();
            m_busy = 1;
            m_pos  = 0;
         end
         if (push_ok) mq.push_back(tx_byte);
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 0;
   always begin
      @(negedge clk);
      if (cmp_en) begin
         check("serial", 32'(tx_serial), 32'(m_busy ? frame_bit(m_byte, m_pos / B) : 1'b1));
         check("active", 32'(tx_active), 32'(m_busy));
         check("done",   32'(tx_done),   32'(m_done));
         check("count",  32'(fifo_count), 32'(mq.size()));
         check("ready",  32'(tx_ready),  32'(mq.size() < D));
      end
   end

   // ---------------- line decoder and activity trackers ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q[$];
   bit         rx_busy = 0;
   int         rx_t    = 0;
   logic [9:0] rx_line = '0;
   logic [9:0] last_line = '0;
   int         start_cyc = 0, done_cyc = 0, act_cycles = 0, act_falls = 0, max_count = 0;
   bit         act_prev = 0, saw_not_ready = 0;

   always begin
      @(negedge clk);
      if (!rst_n) begin
         rx_busy  = 0;
         act_prev = 0;
      end else begin
         if (!rx_busy) begin
            if (tx_serial == 1'b0) begin
               rx_busy = 1;
               rx_t    = 0;
            end
         end else begin
            rx_t++;
         end
         if (rx_busy && (rx_t % B) == B / 2) begin
            rx_line[rx_t / B] = tx_serial;
            if (rx_t / B == 9) begin
               if (rx_line[0] == 1'b0 && rx_line[9] == 1'b1) rx_q.push_back(rx_line[8:1]);
               last_line = rx_line;
               rx_busy   = 0;
            end
         end
         if (tx_active && !act_prev) start_cyc = cyc;
         if (!tx_active && act_prev) act_falls++;
         if (tx_done) done_cyc = cyc;
         if (tx_active) act_cycles++;
         act_prev = tx_active;
         if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
         if (!tx_ready) saw_not_ready = 1;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic push_byte(input logic [7:0] b);
      bit took;
      int guard = 0;
      tx_valid = 1'b1;
      tx_byte  = b;
      do begin
         took = tx_ready;
         @(negedge clk);
         guard++;
      end while (!took && guard < 2000);
      tx_valid = 1'b0;
      if (!took) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_busy || mq.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_in_budget", 32'(n < budget), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_pos(input int pos);
      int n = 0;
      while (!(m_busy && m_pos == pos) && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check("pos_reached", 32'(n < 4 * FRAME), 32'd1);
   endtask

   task automatic clear_stats();
      rx_q.delete();
      act_cycles    = 0;
      act_falls     = 0;
      max_count     = 0;
      saw_not_ready = 0;
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int p;
      int idx;
      bit took;
      int guard;

      // 1: reset state
      #1 rst_n = 1'b0;
      #2 cmp_en = 1;
      check("rst_serial", 32'(tx_serial), 32'd1);
      check("rst_ready",  32'(tx_ready),  32'd1);
      check("rst_active", 32'(tx_active), 32'd0);
      check("rst_count",  32'(fifo_count), 32'd0);
      check("rst_done",   32'(tx_done),   32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // 2: single byte 0x32
      clear_stats();
      p = cyc;
      push_byte(8'h32);
      wait_idle(4 * FRAME);
      check("t2_start_latency", 32'(start_cyc - p), 32'd2);
      check("t2_done_after",    32'(done_cyc - start_cyc), 32'(FRAME));
      check("t2_active_len",    32'(act_cycles), 32'(FRAME));
      check("t2_line",          32'(last_line), 32'b1001100100);
      check("t2_rx_n",          32'(rx_q.size()), 32'd1);
      if (rx_q.size() == 1) check("t2_rx0", 32'(rx_q[0]), 32'h32);

      // 3: back-to-back 0x32, 0xCE
      clear_stats();
      push_byte(8'h32);
      push_byte(8'hCE);
      wait_idle(6 * FRAME);
      check("t3_active_len", 32'(act_cycles), 32'(2 * FRAME));
      check("t3_active_falls", 32'(act_falls), 32'd1);
      check("t3_rx_n", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() == 2) begin
         check("t3_rx0", 32'(rx_q[0]), 32'h32);
         check("t3_rx1", 32'(rx_q[1]), 32'hCE);
      end

      // 4: overflow with valid held high
      clear_stats();
      idx      = 1;
      guard    = 0;
      tx_valid = 1'b1;
      tx_byte  = 8'(idx);
      while (idx <= 8 && guard < 20 * FRAME) begin
         took = tx_valid && tx_ready;
         @(negedge clk);
         guard++;
         if (took) begin
            idx++;
            if (idx > 8) tx_valid = 1'b0;
            else         tx_byte  = 8'(idx);
         end
      end
      tx_valid = 1'b0;
      check("t4_all_offered", 32'(idx), 32'd9);
      wait_idle(12 * FRAME);
      check("t4_max_count", 32'(max_count), 32'd4);
      check("t4_ready_dropped", 32'(saw_not_ready), 32'd1);
      check("t4_rx_n", 32'(rx_q.size()), 32'd8);
      if (rx_q.size() == 8)
         for (int i = 0; i < 8; i++) check("t4_rx_order", 32'(rx_q[i]), 32'(i + 1));

      // 5: reset during data bit 4 of 0xA5 with two bytes queued
      clear_stats();
      push_byte(8'hA5);
      push_byte(8'h11);
      push_byte(8'h22);
      wait_pos(5 * B + B / 2);
      check("t5_queued", 32'(fifo_count), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_serial", 32'(tx_serial), 32'd1);
      check("t5_rst_count",  32'(fifo_count), 32'd0);
      check("t5_rst_active", 32'(tx_active), 32'd0);
      check("t5_rst_ready",  32'(tx_ready),  32'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      clear_stats();
      push_byte(8'h5A);
      wait_idle(4 * FRAME);
      check("t5_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() == 1) check("t5_rx0", 32'(rx_q[0]), 32'h5A);

      // 6: push on the stop-bit end edge with count=1
      clear_stats();
      push_byte(8'h3C);
      push_byte(8'h96);
      check("t6_count_before", 32'(fifo_count), 32'd1);
      wait_pos(FRAME - 1);
      push_byte(8'hC3);
      check("t6_count_after", 32'(fifo_count), 32'd1);
      wait_idle(6 * FRAME);
      check("t6_active_len", 32'(act_cycles), 32'(3 * FRAME));
      check("t6_rx_n", 32'(rx_q.size()), 32'd3);
      if (rx_q.size() == 3) begin
         check("t6_rx0", 32'(rx_q[0]), 32'h3C);
         check("t6_rx1", 32'(rx_q[1]), 32'h96);
         check("t6_rx2", 32'(rx_q[2]), 32'hC3);
      end

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
